// File: rtl/gray_fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO (Gray/binary conversion, sync depth).
package gray_fifo_pkg;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned PTR_MAXW    = 32;

   typedef logic [PTR_MAXW-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = g;
      for (int unsigned i = 1; i < PTR_MAXW; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into the clk domain.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [W-1:0] s1;
   (* ASYNC_REG = "TRUE" *) logic [W-1:0] s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

endmodule

// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller: binary/Gray write pointer, synchronised read pointer, full flag.
// Optional almost_full output enabled by defining GWPTR_ALMOST_FULL_EN.
module gray_wptr_ctrl
   import gray_fifo_pkg::*;
#(
   parameter int AW     = 4,
   parameter int AF_LVL = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_req,
   output logic          wr_accept,
   output logic [AW-1:0] wr_addr,
   output logic [AW:0]   wr_gray,
   input  logic [AW:0]   rd_gray_async,
   output logic          full
`ifdef GWPTR_ALMOST_FULL_EN
  ,output logic          almost_full
`endif
);

   localparam int unsigned PW    = AW + 1;
   localparam int unsigned DEPTH = 1 << AW;

   if (AW < 2 || AF_LVL < 0) begin : g_bad_param
      $error("gray_wptr_ctrl: AW must be >= 2 and AF_LVL >= 0");
   end

   logic [AW:0] wr_bin;
   logic [AW:0] bin_next;
   logic [AW:0] gray_next;
   logic [AW:0] rd_sync;
   logic        full_next;

   sync_2ff #(
      .W (PW)
   ) u_rd_sync (
      .clk (clk),
      .rst (rst),
      .d   (rd_gray_async),
      .q   (rd_sync)
   );

   assign wr_accept = wr_req & ~full & ~rst;
   assign bin_next  = wr_bin + {{AW{1'b0}}, wr_accept};
   assign gray_next = PW'(bin2gray(ptr_t'(bin_next)));
   assign wr_addr   = wr_bin[AW-1:0];

   // Full when the next write pointer is a whole lap ahead: top two Gray bits inverted, rest equal.
   assign full_next = (gray_next == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]});

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bin  <= '0;
         wr_gray <= '0;
         full    <= 1'b0;
      end else begin
         wr_bin  <= bin_next;
         wr_gray <= gray_next;
         full    <= full_next;
      end
   end

`ifdef GWPTR_ALMOST_FULL_EN
   // Threshold form of (DEPTH - used) <= AF_LVL, avoiding a negative intermediate.
   localparam int unsigned AF_THR = (AF_LVL >= DEPTH) ? 0 : DEPTH - AF_LVL;

   logic [AW:0] rd_bin;
   logic [AW:0] used;
   logic        af_next;

   assign rd_bin  = PW'(gray2bin(ptr_t'(rd_sync)));
   assign used    = bin_next - rd_bin;
   assign af_next = (32'(used) >= AF_THR);

   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= af_next;
      end
   end
`endif

endmodule

// File: doc/gray_wptr_ctrl.md
Name: gray_wptr_ctrl

Overview:
Write-side pointer controller for the team's asynchronous FIFO.
- Owns the binary write pointer and converts it to Gray code for export to the read domain.
- Synchronises the incoming read Gray pointer through a two-flop stage and computes a registered full flag.
- Gates write requests into accepted writes and sequences the Binary-to-Gray datapath once per accepted write.

Parameters:
AW, 4, FIFO address width; depth = 2^AW; legal AW >= 2
AF_LVL, 1, almost-full threshold: flag asserts when free slots <= AF_LVL (used only with the optional feature)

Ports:
clk  in  1  write-domain clock
rst  in  1  reset, synchronous, active-high
wr_req  in  1  producer write request
wr_accept  out  1  combinational: wr_req & ~full; RAM write enable
wr_addr  out  AW  RAM write address = wr_bin[AW-1:0]
wr_gray  out  AW+1  registered Gray write pointer, exported to read domain
rd_gray_async  in  AW+1  read Gray pointer from the read domain (asynchronous)
full  out  1  registered full flag
almost_full  out  1  registered; present only with GWPTR_ALMOST_FULL_EN

Behaviour:
- One clock. Reset is synchronous and active-high, ports named clk and rst. Every flop is cleared on a clk edge while rst=1.
- Reset values: wr_bin=0, wr_gray=0, both sync stages=0, full=0, almost_full=0. wr_accept=0 while wr_req=0.
- Internal state: wr_bin [AW:0], the binary pointer with 1 wrap bit.
- bin_next = wr_bin + wr_accept, computed modulo 2^(AW+1). From all-ones it wraps to 0.
- gray_next = bin_next ^ (bin_next >> 1).
- Per edge, all of these update together: wr_bin <= bin_next, wr_gray <= gray_next, full <= (gray_next == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]}).
- Latency: wr_accept in cycle N gives updated wr_addr, wr_gray and full at edge N+1. No bubble is needed between back-to-back writes.
- Synchroniser: rd_gray_async -> s1 -> rd_sync (2 flops). A change on rd_gray_async affects full at the 3rd edge after it.
- wr_req while full=1 is dropped. wr_accept=0 and the pointers hold. No error flag is raised and nothing is queued.
- wr_req while rst=1: wr_accept is forced to 0.
- wr_gray changes exactly one bit per accepted write, including at wrap. It is never driven combinationally.
- full never falls without a read-pointer change, and never rises without a write.
- Reset mid-operation: the pointer and flags return to 0 on that edge. The read side must be reset in the same window; this is the system integrator's responsibility.

Optional Feature:
Macro GWPTR_ALMOST_FULL_EN.
- Defined:
  - rd_sync is converted Gray-to-binary (rd_bin).
  - used = bin_next - rd_bin, computed modulo 2^(AW+1).
  - almost_full <= ((2^AW - used) <= AF_LVL), registered with the same timing as full.
- Undefined:
  - almost_full port and the Gray-to-binary logic are absent.
  - AF_LVL is ignored.

Decomposition:
- Package gray_fifo_pkg:
  - function bin2gray(AW+1)
  - function gray2bin(AW+1)
  - constant SYNC_STAGES=2
  - localparam DEPTH = 1<<AW computed in the module
- Sub-module sync_2ff (parameter W), used for the rd_gray_async crossing. Its flops carry the team's async-register attribute.
- Binary-to-Gray conversion is inline via the package function. No separate instance.

Test Plan:
1. Reset: AW=2, hold rst 3 cycles with wr_req=1 -> wr_accept=0 throughout; after release wr_gray=000, wr_addr=00, full=0.
2. Fill: AW=2, rd_gray_async=000, wr_req=1 for 5 cycles.
   - wr_gray sequence 001,011,010,110; full=1 after the 4th edge.
   - 5th request: wr_accept=0, wr_gray stays 110.
3. Release: from (2), set rd_gray_async=001 -> full=0 exactly 3 edges later; next write gives wr_gray=111, full=1.
4. Wrap: 8 accepted writes with the read pointer tracking -> wr_gray returns to 000, wr_addr=00, and each step changes 1 bit (checked by assertion).
5. Mid-op reset: after 3 writes, pulse rst for 1 cycle -> wr_gray=000, full=0 on that edge; a write the next cycle gives 001.
6. GWPTR_ALMOST_FULL_EN, AW=2, AF_LVL=1, read pointer at 0 -> almost_full=1 after the 3rd write and stays 1 at the 4th (full=1); AF_LVL=0 -> asserts only with full.
